uart_tx_sched: RTL and testbench

Two-channel transmit scheduler in front of the UART parallel-in/serial-out shift register. Accepts bytes from two independent requesters over valid/ready handshakes and arbitrates between them. Builds the 12-bit frame with each channel's own format (data length, parity, stop bits) and sequences the shift register's `send`/`tx_done` protocol, including the reload gap and a stall watchdog.

---
 rtl/uart_tx_sched.sv | 177 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Two-channel transmit scheduler feeding the UART PISO shift register.
// Arbitrates between two valid/ready requesters, builds the 12-bit frame
// from the granted channel's own format, and drives the send/tx_done
// protocol with a one-tick reload gap and a stall watchdog.
//
// Build option: define UART_TX_SCHED_FIXED_PRIO_EN to replace round-robin
// arbitration with fixed priority (channel 0 always wins).

module uart_tx_sched #(
    parameter int TIMEOUT_TICKS = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        baud_tick,
    input  logic [1:0]  req_valid,
    input  logic [7:0]  req_data0,
    input  logic [7:0]  req_data1,
    output logic [1:0]  req_ready,
    input  logic [3:0]  cfg0,
    input  logic [3:0]  cfg1,
    output logic [11:0] frame_out,
    output logic        data_length,
    output logic        stop_bits,
    output logic [1:0]  parity_type,
    output logic        send,
    input  logic        tx_done,
    output logic        busy,
    output logic        active_ch,
    output logic        timeout_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    // Tick count value seen on the last tick the watchdog allows
    localparam logic [3:0] TICK_LAST = 4'(TIMEOUT_TICKS - 1);

    logic [1:0]  state;
    logic [3:0]  tick_cnt;
    logic        grant_ch;
    logic        grant_now;
    logic [7:0]  sel_data;
    logic [3:0]  sel_cfg;
    logic [11:0] sel_frame;

    // Frame layout, bit 0 first on the line: start, data LSB-first,
    // optional parity, then all ones (stop bits and idle fill are both 1).
    function automatic logic [11:0] build_frame(input logic [7:0] data,
                                                input logic       len8,
                                                input logic [1:0] ptype);
        logic [11:0] f;
        logic        par_en;
        logic        par_bit;
        f       = 12'hFFF;
        f[0]    = 1'b0;
        par_en  = ptype[1] ^ ptype[0];
        if (len8) begin
            f[8:1]  = data;
            par_bit = ptype[1] ? (^data) : (~^data);
            if (par_en) begin
                f[9] = par_bit;
            end
        end else begin
            f[7:1]  = data[6:0];
            par_bit = ptype[1] ? (^data[6:0]) : (~^data[6:0]);
            if (par_en) begin
                f[8] = par_bit;
            end
        end
        return f;
    endfunction

    assign grant_now = (state == ST_IDLE) && (|req_valid);

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    // Fixed priority: channel 1 only wins when channel 0 is not requesting
    always_comb begin
        grant_ch = ~req_valid[0];
    end
`else
    logic last_ch;

    // Round-robin: on a tie the channel served last yields
    always_comb begin
        grant_ch = 1'b0;
        if (req_valid == 2'b11) begin
            grant_ch = ~last_ch;
        end else begin
            grant_ch = req_valid[1];
        end
    end

    // Remember the last served channel; reset value makes channel 0 win first
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ch <= 1'b1;
        end else if (grant_now) begin
            last_ch <= grant_ch;
        end
    end
`endif

    assign sel_data  = grant_ch ? req_data1 : req_data0;
    assign sel_cfg   = grant_ch ? cfg1 : cfg0;
    assign sel_frame = build_frame(sel_data, sel_cfg[3], sel_cfg[1:0]);

    // Capture the granted channel's frame and format; held until next grant
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_out   <= 12'hFFF;
            data_length <= 1'b0;
            stop_bits   <= 1'b0;
            parity_type <= 2'b00;
            active_ch   <= 1'b0;
        end else if (grant_now) begin
            frame_out   <= sel_frame;
            data_length <= sel_cfg[3];
            stop_bits   <= sel_cfg[2];
            parity_type <= sel_cfg[1:0];
            active_ch   <= grant_ch;
        end
    end

    // Sequencer: accept, wait a tick for the load, transmit, then one idle tick
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            tick_cnt    <= 4'd0;
            req_ready   <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            req_ready   <= 2'b00;
            timeout_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_now) begin
                        req_ready <= grant_ch ? 2'b10 : 2'b01;
                        state     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (baud_tick) begin
                        tick_cnt <= 4'd0;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (baud_tick) begin
                        if (tx_done) begin
                            state <= ST_GAP;
                        end else if (tick_cnt == TICK_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= ST_GAP;
                        end else begin
                            tick_cnt <= tick_cnt + 4'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (baud_tick) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign send = (state == ST_SEND);

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Scoreboard bench for uart_tx_sched. Requests push hand-computed expected
// frames into a queue; a monitor pops one on every accept pulse and follows
// that frame through LOAD, SEND and GAP. A small shift-register model
// generates baud ticks and tx_done.

module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        baud_tick = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [7:0]  req_data0 = 8'h00;
    logic [7:0]  req_data1 = 8'h00;
    logic [3:0]  cfg0 = 4'h0;
    logic [3:0]  cfg1 = 4'h0;
    logic        tx_done = 1'b0;
    logic [1:0]  req_ready;
    logic [11:0] frame_out;
    logic        data_length;
    logic        stop_bits;
    logic [1:0]  parity_type;
    logic        send;
    logic        busy;
    logic        active_ch;
    logic        timeout_err;

    typedef struct {
        logic        ch;
        logic [11:0] frame;
        logic [3:0]  cfg;
        int          ticks;
        logic        to;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;

    int checks = 0;
    int errors = 0;

    int   div_cnt = 0;
    int   sr_cnt = 0;
    int   bits = 0;
    logic prev_send = 1'b0;
    logic done_en = 1'b1;
    logic glitch_en = 1'b0;
    int   done_at = 0;

    int   phase = 0;
    bit   in_frame = 1'b0;
    int   load_ticks = 0;
    int   send_ticks = 0;
    int   gap_ticks = 0;
    int   timeout_cnt = 0;

    uart_tx_sched #(.TIMEOUT_TICKS(14)) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_tick   (baud_tick),
        .req_valid   (req_valid),
        .req_data0   (req_data0),
        .req_data1   (req_data1),
        .req_ready   (req_ready),
        .cfg0        (cfg0),
        .cfg1        (cfg1),
        .frame_out   (frame_out),
        .data_length (data_length),
        .stop_bits   (stop_bits),
        .parity_type (parity_type),
        .send        (send),
        .tx_done     (tx_done),
        .busy        (busy),
        .active_ch   (active_ch),
        .timeout_err (timeout_err)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic pushExp(input logic ch, input logic [11:0] frame, input logic [3:0] cfg,
                           input int ticks, input logic to);
        exp_t e;
        e.ch    = ch;
        e.frame = frame;
        e.cfg   = cfg;
        e.ticks = ticks;
        e.to    = to;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic ch, input logic [7:0] data, input logic [3:0] cfg,
                                 input logic [11:0] frame, input int ticks, input logic to);
        if (ch) begin
            req_data1 = data;
            cfg1      = cfg;
        end else begin
            req_data0 = data;
            cfg0      = cfg;
        end
        pushExp(ch, frame, cfg, ticks, to);
        req_valid[ch] = 1'b1;
    endtask

    task automatic waitReady(input logic ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (req_ready[ch] === 1'b1) seen = 1'b1;
        end
        #1;
        if (!seen) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_ready ch%0d: no accept pulse, required one within 400 cycles", ch);
        end
        req_valid[ch] = 1'b0;
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 800 && !done; i++) begin
            @(negedge clk);
            #2;
            if (busy === 1'b0 && !in_frame && exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_idle: busy=%b pending=%0d, required idle within 800 cycles",
                     busy, exp_q.size());
        end
    endtask

    task automatic alignToTick();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (div_cnt == 2) break;
        end
        #1;
    endtask

    // Shift-register model: baud ticks every 4 clocks, tx_done on the last bit
    always begin
        @(posedge clk);
        #1;
        if (prev_send && baud_tick) sr_cnt++;
        if (send !== 1'b1) sr_cnt = 0;
        prev_send = (send === 1'b1);
        div_cnt   = (div_cnt + 1) % 4;
        baud_tick = (div_cnt == 3);
        if (done_at != 0) begin
            bits = done_at;
        end else begin
            bits = 1 + (data_length ? 8 : 7)
                 + ((parity_type == 2'b01 || parity_type == 2'b10) ? 1 : 0)
                 + (stop_bits ? 2 : 1);
        end
        tx_done = done_en && (send === 1'b1)
                && ((sr_cnt == bits - 1) || (glitch_en && !baud_tick));
    end

    // Monitor: pop the expected frame on each accept and follow it to idle
    always @(negedge clk) begin
        if (rst) begin
            in_frame = 1'b0;
            phase    = 0;
        end else begin
            if (timeout_err === 1'b1) timeout_cnt++;
            if (req_ready !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_accept: req_ready=%b, required 00", req_ready);
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("req_ready", 12'(req_ready), cur.ch ? 12'h2 : 12'h1);
                    checkOutput("active_ch", 12'(active_ch), 12'(cur.ch));
                    checkOutput("frame_out", frame_out, cur.frame);
                    checkOutput("cfg_out", 12'({data_length, stop_bits, parity_type}), 12'(cur.cfg));
                    checkOutput("busy_at_accept", 12'(busy), 12'h1);
                    in_frame   = 1'b1;
                    phase      = 1;
                    load_ticks = 0;
                    send_ticks = 0;
                    gap_ticks  = 0;
                end
            end
            if (in_frame) begin
                if (phase == 1 && send === 1'b1) begin
                    checkOutput("load_ticks", 12'(load_ticks), 12'h1);
                    phase = 2;
                end else if (phase == 2 && send !== 1'b1) begin
                    checkOutput("send_ticks", 12'(send_ticks), 12'(cur.ticks));
                    checkOutput("timeout_err", 12'(timeout_err), 12'(cur.to));
                    checkOutput("frame_held", frame_out, cur.frame);
                    checkOutput("cfg_held", 12'({data_length, stop_bits, parity_type}), 12'(cur.cfg));
                    phase = 3;
                end else if (phase == 3 && busy === 1'b0) begin
                    checkOutput("gap_ticks", 12'(gap_ticks), 12'h1);
                    in_frame = 1'b0;
                    phase    = 0;
                end
                if (baud_tick) begin
                    case (phase)
                        1:       load_ticks++;
                        2:       send_ticks++;
                        3:       gap_ticks++;
                        default: ;
                    endcase
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        bit hit;
        int n;

        repeat (3) @(negedge clk);
        checkOutput("rst_send", 12'(send), 12'h0);
        checkOutput("rst_req_ready", 12'(req_ready), 12'h0);
        checkOutput("rst_busy", 12'(busy), 12'h0);
        checkOutput("rst_active_ch", 12'(active_ch), 12'h0);
        checkOutput("rst_timeout_err", 12'(timeout_err), 12'h0);
        checkOutput("rst_frame_out", frame_out, 12'hFFF);
        checkOutput("rst_data_length", 12'(data_length), 12'h0);
        checkOutput("rst_stop_bits", 12'(stop_bits), 12'h0);
        checkOutput("rst_parity_type", 12'(parity_type), 12'h0);
        #1 rst = 1'b0;

        $display("[TB] single frame, 8-bit odd parity");
        @(negedge clk);
        #1;
        applyStimulus(1'b0, 8'hA5, 4'b1001, 12'hF4A, 11, 1'b0);
        waitReady(1'b0);
        waitIdle();

        $display("[TB] 7-bit two stop bits, grant on a tick, tx_done glitches");
        glitch_en = 1'b1;
        alignToTick();
        applyStimulus(1'b1, 8'hFF, 4'b0100, 12'hFFE, 10, 1'b0);
        waitReady(1'b1);
        waitIdle();
        glitch_en = 1'b0;

        $display("[TB] 8-bit even parity two stop, 7-bit odd parity");
        applyStimulus(1'b0, 8'h3C, 4'b1110, 12'hC78, 12, 1'b0);
        waitReady(1'b0);
        waitIdle();
        applyStimulus(1'b1, 8'h81, 4'b0001, 12'hE02, 10, 1'b0);
        waitReady(1'b1);
        waitIdle();

        $display("[TB] both channels requesting for four frames");
        req_data0 = 8'h12;
        cfg0      = 4'b1000;
        req_data1 = 8'h34;
        cfg1      = 4'b1011;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) pushExp(1'b0, 12'hE24, 4'b1000, 10, 1'b0);
`else
        for (int i = 0; i < 2; i++) begin
            pushExp(1'b0, 12'hE24, 4'b1000, 10, 1'b0);
            pushExp(1'b1, 12'hE68, 4'b1011, 10, 1'b0);
        end
`endif
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 1500 && n < 4; i++) begin
            @(negedge clk);
            if (req_ready !== 2'b00) n++;
        end
        #1;
        req_valid = 2'b00;
        if (n < 4) begin
            checks++;
            errors++;
            $display("[TB] FAIL rr_accepts: got %0d accepts, required 4", n);
        end
        waitIdle();

        $display("[TB] watchdog with tx_done stuck low");
        done_en = 1'b0;
        applyStimulus(1'b0, 8'hA5, 4'b1001, 12'hF4A, 14, 1'b1);
        waitReady(1'b0);
        waitIdle();
        done_en = 1'b1;

        $display("[TB] tx_done on the watchdog's last tick");
        done_at = 14;
        applyStimulus(1'b1, 8'h0F, 4'b1000, 12'hE1E, 14, 1'b0);
        waitReady(1'b1);
        waitIdle();
        done_at = 0;

        $display("[TB] reset on send tick 5 with channel 1 pending");
        applyStimulus(1'b0, 8'hA5, 4'b1001, 12'hF4A, 11, 1'b0);
        waitReady(1'b0);
        applyStimulus(1'b1, 8'h81, 4'b0001, 12'hE02, 10, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (send === 1'b1 && sr_cnt == 4 && baud_tick) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_tick5: send tick 5 not reached, required within 400 cycles");
        end
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_send", 12'(send), 12'h0);
        checkOutput("midrst_busy", 12'(busy), 12'h0);
        checkOutput("midrst_frame_out", frame_out, 12'hFFF);
        checkOutput("midrst_req_ready", 12'(req_ready), 12'h0);
        #1 rst = 1'b0;
        waitReady(1'b1);
        waitIdle();

        $display("[TB] config change during send, short-lived channel 1 request");
        applyStimulus(1'b0, 8'hA5, 4'b1001, 12'hF4A, 11, 1'b0);
        waitReady(1'b0);
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (send === 1'b1) hit = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_send: send stayed low, required high within 100 cycles");
        end
        #1;
        cfg0         = 4'b0110;
        req_data0    = 8'h00;
        req_data1    = 8'h77;
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        #1 req_valid[1] = 1'b0;
        waitIdle();

        @(negedge clk);
        #2;
        checkOutput("queue_empty", 12'(exp_q.size()), 12'h0);
        checkOutput("timeout_pulses", 12'(timeout_cnt), 12'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
